// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: fetch control, redirect, instruction ROM port and decode handshake.
// master = fetch_controller side, slave = environment (decode/ROM/branch unit).
interface fetch_controller_if;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, rom_data, if_ready,
        output rom_addr, if_valid, if_instr, if_pc, fetch_fault
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, rom_data, if_ready,
        input  rom_addr, if_valid, if_instr, if_pc, fetch_fault
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC register, combinational ROM port, 2-entry {pc, instr} FIFO.
// Optional macro FETCH_BOUND_CHECK_EN replaces out-of-range fetches with a NOP and raises fetch_fault.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    fetch_controller_if.master        bus
);

    logic [31:0] pc_q;
    logic [1:0]  occ_q;
    logic [1:0]  occ_next;
    logic [31:0] slot_pc    [2];
    logic [31:0] slot_instr [2];
    logic        pop;
    logic        push;
    logic        wr_hi;
    logic [31:0] fetch_word;

    assign bus.rom_addr = pc_q;
    assign bus.if_valid = (occ_q != 2'd0) && !bus.redirect_valid;
    assign bus.if_pc    = slot_pc[0];
    assign bus.if_instr = slot_instr[0];

    assign pop  = bus.if_valid && bus.if_ready;
    assign push = bus.fetch_en && !bus.redirect_valid && ((occ_q != 2'd2) || pop);

    // Slot 0 is always the head; a push lands behind whatever survives this cycle's pop.
    assign wr_hi = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);

    always_comb begin
        occ_next = occ_q;
        case ({push, pop})
            2'b10:   occ_next = occ_q + 2'd1;
            2'b01:   occ_next = occ_q - 2'd1;
            default: occ_next = occ_q;
        endcase
    end

`ifdef FETCH_BOUND_CHECK_EN
    localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS) * 33'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic oob;
    logic fault_q;

    assign oob        = ({1'b0, pc_q} >= ROM_BYTES);
    assign fetch_word = oob ? NOP_INSTR : bus.rom_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            fault_q <= 1'b0;
        end else if (push && oob) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.fetch_fault = fault_q;
`else
    logic unused_rom_words;

    assign unused_rom_words = ^ROM_WORDS;
    assign fetch_word       = bus.rom_data;
    assign bus.fetch_fault  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            occ_q <= 2'd0;
        end else if (bus.redirect_valid) begin
            pc_q  <= {bus.redirect_pc[31:2], 2'b00};
            occ_q <= 2'd0;
        end else begin
            if (push) begin
                pc_q <= pc_q + 32'd4;
            end
            occ_q <= occ_next;
        end
    end

    // Payload needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !bus.redirect_valid) begin
            if (pop) begin
                slot_pc[0]    <= slot_pc[1];
                slot_instr[0] <= slot_instr[1];
            end
            if (push) begin
                if (wr_hi) begin
                    slot_pc[1]    <= pc_q;
                    slot_instr[1] <= fetch_word;
                end else begin
                    slot_pc[0]    <= pc_q;
                    slot_instr[0] <= fetch_word;
                end
            end
        end
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL provide parameter ROM_WORDS, default 256, the instruction ROM depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fetch_en  input  1  allows new ROM fetches when high.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target address.
REQ-008 SHALL have port rom_addr  output  32  byte address driven to the combinational instruction ROM.
REQ-009 SHALL have port rom_data  input  32  ROM read word, valid in the same cycle as rom_addr.
REQ-010 SHALL have port if_valid  output  1  head instruction available to decode.
REQ-011 SHALL have port if_ready  input  1  decode accepts the head this cycle.
REQ-012 SHALL have port if_instr  output  32  head instruction word.
REQ-013 SHALL have port if_pc  output  32  address of the head instruction.
REQ-014 SHALL have port fetch_fault  output  1  sticky out-of-range fetch flag.

Function
REQ-015 SHALL hold a fetch PC register; rom_addr SHALL equal the fetch PC combinationally.
REQ-016 SHALL contain a 2-entry FIFO of {pc, instr} with occupancy 0..2.
REQ-017 A fetch SHALL occur in a cycle when fetch_en=1, redirect_valid=0, and (occupancy<2 or a pop occurs); it writes {rom_addr, rom_data} at the clock edge and increments the PC by 4.
REQ-018 The PC SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 -> 0).
REQ-019 A pop SHALL occur when if_valid=1 and if_ready=1; a simultaneous pop and push at occupancy 2 SHALL keep occupancy at 2.
REQ-020 if_valid SHALL be 1 when occupancy>0 and redirect_valid=0; if_instr/if_pc SHALL show the oldest entry.
REQ-021 Fetch-to-if_valid latency SHALL be one cycle: an entry written at edge N is visible in cycle N+1.
REQ-022 On redirect_valid=1, the FIFO SHALL be flushed, no push or pop SHALL occur, and the PC SHALL load {redirect_pc[31:2],2'b00} at the clock edge.
REQ-023 With fetch_en=0, the PC SHALL hold, and the FIFO SHALL continue to drain.
REQ-024 Redirect SHALL take priority over fetch_en, pop, and push in the same cycle.

Reset
REQ-025 While reset=1 at a clock edge: PC<=RESET_PC, occupancy<=0, fetch_fault<=0; if_valid SHALL therefore be 0 in the cycle after reset.
REQ-026 Reset asserted mid-operation SHALL discard all FIFO entries and any pending redirect.

Configuration
REQ-027 With macro FETCH_BOUND_CHECK_EN defined, a fetch with rom_addr >= ROM_WORDS*4 SHALL store instr 32'h00000013 (NOP) instead of rom_data and SHALL set fetch_fault.
REQ-028 With FETCH_BOUND_CHECK_EN defined, fetch_fault SHALL clear only on reset or an accepted redirect.
REQ-029 Without FETCH_BOUND_CHECK_EN, rom_data SHALL be stored unmodified and fetch_fault SHALL be constant 0.

Verification
REQ-030 Reset, then fetch_en=1, if_ready=1, ROM word0=32'h00a00093 -> cycle 1: if_valid=1, if_pc=0, if_instr=32'h00a00093; then consecutive pcs 4, 8, ... on every cycle.
REQ-031 if_ready=0 for 5 cycles -> occupancy saturates at 2, rom_addr holds at 8, and if_pc stays 0; release -> pcs 0, 4, 8 emitted in order, with none lost or duplicated.
REQ-032 Redirect to 32'h00000022 while occupancy=2 and if_ready=1 -> if_valid=0 that cycle, and the next if_pc=32'h00000020.
REQ-033 PC preloaded via redirect to 32'hFFFFFFFC -> successive if_pc values are FFFFFFFC, then 00000000.
REQ-034 With FETCH_BOUND_CHECK_EN, redirect to 32'h00000400 (ROM_WORDS=256) -> if_instr=32'h00000013 and fetch_fault=1 until a redirect to 0 -> fetch_fault=0.
REQ-035 Reset asserted with occupancy=2 -> next cycle if_valid=0, and the next cycle after that if_pc=RESET_PC.
